// File: rtl/memory_cycle.sv
// MEM stage of the RV32 pipeline: word-addressed data memory plus the M->W register.
// Optional misalignment checking is enabled by defining MEM_MISALIGN_CHECK_EN.
module memory_cycle #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              ResultSrcM,
  input  logic [4:0]        RdM,
  input  logic [31:0]       PCPlus4M,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic              StallW,
  input  logic              FlushW,
  output logic              RegWriteW,
  output logic              ResultSrcW,
  output logic [4:0]        RdW,
  output logic [31:0]       PCPlus4W,
  output logic [DATA_W-1:0] ALUResultW,
  output logic [DATA_W-1:0] ReadDataW,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic              MisalignW,
`endif
  output logic [DATA_W-1:0] ResultW
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] read_data;
  logic              mem_we;
  logic              reg_write_next;

  // Byte offset and bits above the array span are dropped, so addresses wrap.
  assign idx       = ALUResultM[ADDR_W+1:2];
  assign read_data = mem[idx];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{ALUResultM[DATA_W-1:ADDR_W+2], ALUResultM[1:0]};

`ifdef MEM_MISALIGN_CHECK_EN
  logic misaligned;
  assign misaligned     = (ALUResultM[1:0] != 2'b00) & (MemWriteM | ResultSrcM);
  assign mem_we         = MemWriteM & ~misaligned;
  assign reg_write_next = RegWriteM & ~(misaligned & ResultSrcM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MisalignW <= 1'b0;
    end else if (FlushW) begin
      MisalignW <= 1'b0;
    end else if (!StallW) begin
      MisalignW <= misaligned;
    end
  end
`else
  assign mem_we         = MemWriteM;
  assign reg_write_next = RegWriteM;
`endif

  // Store ignores stall/flush; rst gates it so a store caught by reset is lost.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem[idx] <= WriteDataM;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 1'b0;
      RdW        <= '0;
      PCPlus4W   <= '0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
    end else if (FlushW) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 1'b0;
      RdW        <= '0;
      PCPlus4W   <= PCPlus4M;
      ALUResultW <= ALUResultM;
      ReadDataW  <= read_data;
    end else if (!StallW) begin
      RegWriteW  <= reg_write_next;
      ResultSrcW <= ResultSrcM;
      RdW        <= RdM;
      PCPlus4W   <= PCPlus4M;
      ALUResultW <= ALUResultM;
      ReadDataW  <= read_data;
    end
  end

  assign ResultW = ResultSrcW ? ReadDataW : ALUResultW;

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: a reference model pushes expected W-register
// contents into a scoreboard queue each cycle; they are popped and checked after the edge.
module tb_memory_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, ResultSrcM, StallW, FlushW;
  logic [4:0]  RdM;
  logic [31:0] PCPlus4M, ALUResultM, WriteDataM;
  logic        RegWriteW, ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] PCPlus4W, ALUResultW, ReadDataW, ResultW;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        MisalignW;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rw;
    logic        rs;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        known;
    logic        mis;
  } w_t;

  w_t          w_model;
  w_t          sb[$];
  logic [31:0] mem_m [int];

  memory_cycle #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RdM(RdM), .PCPlus4M(PCPlus4M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .StallW(StallW), .FlushW(FlushW),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW), .PCPlus4W(PCPlus4W),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
`ifdef MEM_MISALIGN_CHECK_EN
    .MisalignW(MisalignW),
`endif
    .ResultW(ResultW)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".RegWriteW"}, {31'b0, RegWriteW}, 32'h0);
    chk({tag, ".ResultSrcW"}, {31'b0, ResultSrcW}, 32'h0);
    chk({tag, ".RdW"}, {27'b0, RdW}, 32'h0);
    chk({tag, ".PCPlus4W"}, PCPlus4W, 32'h0);
    chk({tag, ".ALUResultW"}, ALUResultW, 32'h0);
    chk({tag, ".ReadDataW"}, ReadDataW, 32'h0);
    chk({tag, ".ResultW"}, ResultW, 32'h0);
`ifdef MEM_MISALIGN_CHECK_EN
    chk({tag, ".MisalignW"}, {31'b0, MisalignW}, 32'h0);
`endif
  endtask

  task automatic check_w(input string tag);
    w_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".RegWriteW"}, {31'b0, RegWriteW}, {31'b0, e.rw});
    chk({tag, ".ResultSrcW"}, {31'b0, ResultSrcW}, {31'b0, e.rs});
    chk({tag, ".RdW"}, {27'b0, RdW}, {27'b0, e.rd});
    chk({tag, ".PCPlus4W"}, PCPlus4W, e.pc);
    chk({tag, ".ALUResultW"}, ALUResultW, e.alu);
    if (e.known) chk({tag, ".ReadDataW"}, ReadDataW, e.rdata);
    if (!e.rs) chk({tag, ".ResultW"}, ResultW, e.alu);
    else if (e.known) chk({tag, ".ResultW"}, ResultW, e.rdata);
`ifdef MEM_MISALIGN_CHECK_EN
    chk({tag, ".MisalignW"}, {31'b0, MisalignW}, {31'b0, e.mis});
`endif
  endtask

  // One clock: drive M inputs, predict the W register, step, then compare.
  task automatic cyc(input string tag, input logic rw, input logic mw, input logic rs,
                     input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] alu,
                     input logic [31:0] wd, input logic stall, input logic flush);
    w_t   e;
    int   idx;
    logic mis;
    logic mw_eff;
    logic rw_eff;
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RdM = rd;
    PCPlus4M = pc; ALUResultM = alu; WriteDataM = wd; StallW = stall; FlushW = flush;
    idx = int'(alu[11:2]);
    mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    mis = (alu[1:0] != 2'b00) && (mw || rs);
`endif
    mw_eff = mw && !mis;
    rw_eff = rw && !(mis && rs);
    e = w_model;
    if (flush || !stall) begin
      e.pc    = pc;
      e.alu   = alu;
      e.known = mem_m.exists(idx);
      e.rdata = e.known ? mem_m[idx] : 32'h0;
      e.rw    = flush ? 1'b0 : rw_eff;
      e.rs    = flush ? 1'b0 : rs;
      e.rd    = flush ? 5'd0 : rd;
      e.mis   = flush ? 1'b0 : mis;
    end
    if (mw_eff) mem_m[idx] = wd;
    w_model = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_w(tag);
  endtask

  initial begin
    w_model = '{rw: 1'b0, rs: 1'b0, rd: 5'd0, pc: 32'h0, alu: 32'h0,
                rdata: 32'h0, known: 1'b1, mis: 1'b0};
    rst = 1'b1;
    RegWriteM = 1'b1; MemWriteM = 1'b1; ResultSrcM = 1'b1; RdM = 5'd7;
    PCPlus4M = 32'h100; ALUResultM = 32'h40; WriteDataM = 32'hBAD0BAD0;
    StallW = 1'b0; FlushW = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_held");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero("reset_release");
    @(posedge clk);
    #1;

    // Store then load, with register write on the load
    cyc("store_10", 1'b0, 1'b1, 1'b0, 5'd0, 32'h04, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
    cyc("load_10", 1'b1, 1'b0, 1'b1, 5'd5, 32'h08, 32'h10, 32'h0, 1'b0, 1'b0);
    // Same-cycle read-during-write returns the old word
    cyc("store_4", 1'b0, 1'b1, 1'b0, 5'd0, 32'h0C, 32'h4, 32'h1111, 1'b0, 1'b0);
    cyc("raw_same", 1'b1, 1'b1, 1'b1, 5'd6, 32'h10, 32'h4, 32'h2222, 1'b0, 1'b0);
    cyc("raw_next", 1'b1, 1'b0, 1'b1, 5'd6, 32'h14, 32'h4, 32'h0, 1'b0, 1'b0);
    // Address wrap modulo DEPTH*4
    cyc("wrap_store", 1'b0, 1'b1, 1'b0, 5'd0, 32'h18, 32'h1000, 32'hA5A5A5A5, 1'b0, 1'b0);
    cyc("wrap_load", 1'b1, 1'b0, 1'b1, 5'd8, 32'h1C, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc("alu_op", 1'b1, 1'b0, 1'b0, 5'd3, 32'h20, 32'h1234, 32'h0, 1'b0, 1'b0);
    // Stall holds W but the store still lands
    cyc("stall_1", 1'b1, 1'b1, 1'b1, 5'd12, 32'h24, 32'h20, 32'h5555, 1'b1, 1'b0);
    cyc("stall_2", 1'b1, 1'b0, 1'b0, 5'd13, 32'h28, 32'h777, 32'h0, 1'b1, 1'b0);
    cyc("load_20", 1'b1, 1'b0, 1'b1, 5'd14, 32'h2C, 32'h20, 32'h0, 1'b0, 1'b0);
    cyc("store_again", 1'b0, 1'b1, 1'b0, 5'd0, 32'h30, 32'h20, 32'h5555, 1'b0, 1'b0);
    cyc("flush_stall", 1'b1, 1'b0, 1'b1, 5'd9, 32'h34, 32'h10, 32'h0, 1'b1, 1'b1);
    cyc("flush_only", 1'b1, 1'b0, 1'b0, 5'd10, 32'h38, 32'hABC0, 32'h0, 1'b0, 1'b1);

    // Reset asserted mid-store: W clears at once and the store is lost
    RegWriteM = 1'b0; MemWriteM = 1'b1; ResultSrcM = 1'b0; RdM = 5'd0;
    PCPlus4M = 32'h3C; ALUResultM = 32'h10; WriteDataM = 32'hBADBAD00;
    #2 rst = 1'b0;
    #1;
    chk_zero("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    w_model = '{rw: 1'b0, rs: 1'b0, rd: 5'd0, pc: 32'h0, alu: 32'h0,
                rdata: 32'h0, known: 1'b1, mis: 1'b0};
    cyc("lost_store", 1'b1, 1'b0, 1'b1, 5'd11, 32'h40, 32'h10, 32'h0, 1'b0, 1'b0);

`ifdef MEM_MISALIGN_CHECK_EN
    cyc("mis_store", 1'b0, 1'b1, 1'b0, 5'd0, 32'h44, 32'h13, 32'h99999999, 1'b0, 1'b0);
    cyc("mis_check", 1'b1, 1'b0, 1'b1, 5'd1, 32'h48, 32'h10, 32'h0, 1'b0, 1'b0);
    cyc("mis_load", 1'b1, 1'b0, 1'b1, 5'd2, 32'h4C, 32'h22, 32'h0, 1'b0, 1'b0);
`else
    cyc("offset_ignored", 1'b1, 1'b0, 1'b1, 5'd2, 32'h44, 32'h13, 32'h0, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
